// File: rtl/lcd_pkg.sv
// lcd_pkg: shared command encodings, host FSM states and image size for the LCD host
package lcd_pkg;

    typedef enum logic [3:0] {
        CMD_WRITE       = 4'd0,
        CMD_SHIFT_UP    = 4'd1,
        CMD_SHIFT_DOWN  = 4'd2,
        CMD_SHIFT_LEFT  = 4'd3,
        CMD_SHIFT_RIGHT = 4'd4,
        CMD_MAX         = 4'd5,
        CMD_MIN         = 4'd6,
        CMD_AVERAGE     = 4'd7,
        CMD_CCW_ROTATE  = 4'd8,
        CMD_CW_ROTATE   = 4'd9,
        CMD_MIRROR_X    = 4'd10,
        CMD_MIRROR_Y    = 4'd11
    } lcd_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_WAIT_RDY,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_DRAIN,
        ST_FIN
    } host_state_e;

    localparam int IMG_WORDS = 64;

endpackage

// File: rtl/lcd_iram_monitor.sv
// lcd_iram_monitor: sinks the controller's IRAM write stream, summing data and checking order/count
//   i_clear        : zero checksum and count (start of a run)
//   i_en           : high while the host is draining the image
//   i_valid/a/d    : controller IRAM write strobe, address, data
//   i_done         : controller image-write complete
//   o_checksum     : 14-bit wrapping sum of accepted data
//   o_wr_count     : accepted write count
//   o_err          : one-cycle pulse on an out-of-order address or a wrong final count
module lcd_iram_monitor #(
    parameter int IMG_WORDS = lcd_pkg::IMG_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic        i_valid,
    input  logic        i_done,
    input  logic [5:0]  i_a,
    input  logic [7:0]  i_d,
    output logic [13:0] o_checksum,
    output logic [6:0]  o_wr_count,
    output logic        o_err
);
    logic [13:0] r_checksum;
    logic [6:0]  r_wr_count;
    logic        w_hit;
    logic [6:0]  w_count_next;

    assign w_hit        = i_en && i_valid;
    // A write arriving with done is counted before the final count check.
    assign w_count_next = r_wr_count + 7'(w_hit);
    assign o_err        = (w_hit && i_a != r_wr_count[5:0]) ||
                          (i_en && i_done && w_count_next != 7'(IMG_WORDS));
    assign o_checksum   = r_checksum;
    assign o_wr_count   = r_wr_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_checksum <= '0;
            r_wr_count <= '0;
        end else if (i_clear) begin
            r_checksum <= '0;
            r_wr_count <= '0;
        end else if (w_hit) begin
            r_checksum <= r_checksum + {6'd0, i_d};
            r_wr_count <= w_count_next;
        end
    end

endmodule

// File: rtl/lcd_cmd_host.sv
// lcd_cmd_host: replays a command script from ROM to the LCD controller and sinks its image write
//   i_start                 : begin a run (honoured in IDLE/FIN only)
//   o_crom_rd/o_crom_a      : command ROM read, data returns on i_crom_q one cycle later
//   i_busy/i_done           : controller handshake; commands accepted only when busy is low
//   o_cmd/o_cmd_valid       : command and its one-cycle strobe
//   i_iram_valid/a/d        : controller IRAM write stream
//   o_host_busy/o_finished  : run in progress / run complete
//   o_checksum/o_wr_count   : image sum and write count
//   o_err                   : sticky error, cleared by reset or start
module lcd_cmd_host #(
    parameter int CMD_AW    = 6,
    parameter int IMG_WORDS = lcd_pkg::IMG_WORDS,
    parameter int ACK_TMO   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    output logic              o_crom_rd,
    output logic [CMD_AW-1:0] o_crom_a,
    input  logic [3:0]        i_crom_q,
    input  logic              i_busy,
    input  logic              i_done,
    output logic [3:0]        o_cmd,
    output logic              o_cmd_valid,
    input  logic              i_iram_valid,
    input  logic [5:0]        i_iram_a,
    input  logic [7:0]        i_iram_d,
    output logic              o_host_busy,
    output logic              o_finished,
    output logic [13:0]       o_checksum,
    output logic [6:0]        o_wr_count,
    output logic              o_err
);
    import lcd_pkg::*;

    localparam int TW = $clog2(ACK_TMO + 1);

    host_state_e       r_state, w_next;
    logic [CMD_AW-1:0] r_crom_a;
    logic [3:0]        r_cmd;
    logic              r_forced;
    logic [TW-1:0]     r_tmo;
    logic              r_err;
    logic              w_go;
    logic              w_tmo;
    logic              w_mon_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_tmo  = 1'b0;
        w_go   = (r_state == ST_IDLE || r_state == ST_FIN) && i_start;
        case (r_state)
            ST_IDLE, ST_FIN: w_next = i_start ? ST_FETCH : r_state;
            ST_FETCH:        w_next = ST_LATCH;
            ST_LATCH:        w_next = ST_WAIT_RDY;
            ST_WAIT_RDY:     w_next = i_busy ? ST_WAIT_RDY : ST_ISSUE;
            ST_ISSUE:        w_next = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                w_tmo  = !i_busy && r_tmo == TW'(ACK_TMO - 1);
                w_next = i_busy ? (r_cmd == CMD_WRITE ? ST_DRAIN : r_forced ? ST_WAIT_RDY : ST_FETCH)
                                : (w_tmo ? ST_ISSUE : ST_WAIT_ACK);
            end
            ST_DRAIN:        w_next = i_done ? ST_FIN : ST_DRAIN;
            default:         w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_crom_a <= '0;
            r_cmd    <= '0;
            r_forced <= 1'b0;
            r_tmo    <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_go) r_crom_a <= '0;
            // A non-WRITE in the last ROM slot leaves the script unterminated, so a WRITE is appended.
            if (r_state == ST_LATCH) begin
                r_cmd    <= i_crom_q;
                r_forced <= (&r_crom_a) && i_crom_q != CMD_WRITE;
            end
            if (r_state == ST_ISSUE)
                r_tmo <= '0;
            else if (r_state == ST_WAIT_ACK && !i_busy)
                r_tmo <= r_tmo + TW'(1);
            if (r_state == ST_WAIT_ACK && i_busy && r_cmd != CMD_WRITE) begin
                if (r_forced) begin
                    r_cmd    <= CMD_WRITE;
                    r_forced <= 1'b0;
                end else begin
                    r_crom_a <= r_crom_a + CMD_AW'(1);
                end
            end
            r_err <= w_go ? 1'b0
                          : r_err | w_tmo | w_mon_err | (i_iram_valid && r_state != ST_DRAIN);
        end
    end

    lcd_iram_monitor #(.IMG_WORDS(IMG_WORDS)) u_mon (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_go),
        .i_en       (r_state == ST_DRAIN),
        .i_valid    (i_iram_valid),
        .i_done     (i_done),
        .i_a        (i_iram_a),
        .i_d        (i_iram_d),
        .o_checksum (o_checksum),
        .o_wr_count (o_wr_count),
        .o_err      (w_mon_err)
    );

    assign o_crom_rd   = r_state == ST_FETCH;
    assign o_crom_a    = r_crom_a;
    assign o_cmd       = r_cmd;
    assign o_cmd_valid = r_state == ST_ISSUE;
    assign o_host_busy = !(r_state == ST_IDLE || r_state == ST_FIN);
    assign o_finished  = r_state == ST_FIN;
    assign o_err       = r_err;

endmodule

// File: tb/tb_lcd_cmd_host.sv
// tb_lcd_cmd_host: drives lcd_cmd_host with a ROM model and a behavioural LCD controller
module tb_lcd_cmd_host;
    logic        clk, reset, start;
    logic        crom_rd;
    logic [5:0]  crom_a;
    logic [3:0]  crom_q;
    logic        busy, done;
    logic [3:0]  cmd;
    logic        cmd_valid;
    logic        iram_valid;
    logic [5:0]  iram_a;
    logic [7:0]  iram_d;
    logic        host_busy, finished, err;
    logic [13:0] checksum;
    logic [6:0]  wr_count;

    lcd_cmd_host dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (start),
        .o_crom_rd    (crom_rd),
        .o_crom_a     (crom_a),
        .i_crom_q     (crom_q),
        .i_busy       (busy),
        .i_done       (done),
        .o_cmd        (cmd),
        .o_cmd_valid  (cmd_valid),
        .i_iram_valid (iram_valid),
        .i_iram_a     (iram_a),
        .i_iram_d     (iram_d),
        .o_host_busy  (host_busy),
        .o_finished   (finished),
        .o_checksum   (checksum),
        .o_wr_count   (wr_count),
        .o_err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scenario knobs, written only by the main sequence.
    logic [3:0] rom [0:63];
    logic [7:0] wd  [0:63];
    int run_id = 0, ignore_n = 0, n_writes = 64, swap_at = -1;
    bit same_done = 0, stray_en = 0;

    int n_tests = 0, n_fail = 0;

    // Command ROM: data for the address read last cycle, garbage otherwise.
    int f_run = -1, nf = 0;
    int fetch_a [0:255];
    bit rd_prev = 0;
    logic [5:0] a_prev = '0;
    always @(negedge clk) begin
        if (f_run != run_id) begin
            f_run = run_id;
            nf = 0;
        end
        crom_q = rd_prev ? rom[a_prev] : 4'($urandom);
        rd_prev = crom_rd;
        a_prev = crom_a;
        if (crom_rd) begin
            if (nf < 256) fetch_a[nf] = int'(crom_a);
            nf++;
        end
    end

    // Controller model: logs every cmd_valid, ignores the first ignore_n, streams the image on WRITE.
    int c_run = -1, pulses = 0, phase = 0, hold = 0, widx = 0, multi = 0;
    bit stray_done = 0, cv_prev = 0;
    logic [3:0] issued [0:255];
    always @(negedge clk) begin
        iram_valid = 1'b0;
        done = 1'b0;
        if (cmd_valid && cv_prev) multi++;
        cv_prev = cmd_valid;
        if (c_run != run_id) begin
            c_run = run_id;
            pulses = 0;
            phase = 0;
            busy = 1'b0;
            stray_done = 0;
        end
        if (reset) begin
            phase = 0;
            busy = 1'b0;
        end else begin
            case (phase)
                0: begin
                    if (stray_en && !stray_done) begin
                        iram_valid = 1'b1;
                        iram_a = 6'd0;
                        iram_d = 8'hff;
                        stray_done = 1;
                    end
                    if (cmd_valid) begin
                        if (pulses < 256) issued[pulses] = cmd;
                        pulses++;
                        if (pulses > ignore_n) begin
                            busy = 1'b1;
                            hold = 2 + int'($urandom_range(0, 3));
                            phase = (cmd == 4'd0) ? 2 : 1;
                            widx = 0;
                        end
                    end
                end
                1: begin
                    hold--;
                    if (hold == 0) begin
                        busy = 1'b0;
                        phase = 0;
                    end
                end
                2: begin
                    hold--;
                    if (hold == 0) phase = 3;
                end
                3: begin
                    if (widx < n_writes) begin
                        if ($urandom_range(0, 3) != 0) begin
                            iram_valid = 1'b1;
                            iram_a = 6'((swap_at >= 0 && widx == swap_at) ? swap_at + 1 :
                                        (swap_at >= 0 && widx == swap_at + 1) ? swap_at : widx);
                            iram_d = wd[widx];
                            widx++;
                            if (widx == n_writes && same_done) begin
                                done = 1'b1;
                                phase = 4;
                            end
                        end
                    end else begin
                        done = 1'b1;
                        phase = 4;
                    end
                end
                default: begin
                    busy = 1'b0;
                    phase = 0;
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Expected results come straight from the script rules: commands up to and including the first
    // WRITE (or the whole ROM plus an appended WRITE), a repeat for each ignored strobe, and the image sum.
    task automatic run(input string tag);
        logic [3:0]  exp_q[$];
        int          nfe;
        logic [13:0] sum;
        logic        exp_err;
        exp_q = {};
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(rom[i]);
            if (rom[i] == 4'd0) break;
        end
        nfe = exp_q.size();
        if (exp_q[$] != 4'd0) exp_q.push_back(4'd0);
        for (int i = 0; i < ignore_n; i++) exp_q.push_front(exp_q[0]);
        sum = '0;
        for (int i = 0; i < n_writes; i++) sum += 14'(wd[i]);
        exp_err = ignore_n > 0 || swap_at >= 0 || n_writes != 64;
        run_id++;
        pulse_start();
        chk({tag, " host_busy"}, 32'(host_busy), 1);
        repeat (20) @(negedge clk);
        pulse_start();
        for (int i = 0; i < 6000 && !finished; i++) begin
            @(negedge clk);
            #1;
        end
        chk({tag, " finished"}, 32'(finished), 1);
        chk({tag, " idle"}, 32'(host_busy), 0);
        chk({tag, " n_cmds"}, 32'(pulses), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < pulses && i < 256; i++)
            chk($sformatf("%s cmd%0d", tag, i), 32'(issued[i]), 32'(exp_q[i]));
        chk({tag, " n_fetch"}, 32'(nf), 32'(nfe));
        for (int i = 0; i < nfe && i < nf && i < 256; i++)
            chk($sformatf("%s fetch%0d", tag, i), 32'(fetch_a[i]), 32'(i));
        chk({tag, " checksum"}, 32'(checksum), 32'(sum));
        chk({tag, " wr_count"}, 32'(wr_count), 32'(n_writes));
        chk({tag, " err"}, 32'(err), 32'(exp_err));
        chk({tag, " strobe_width"}, 32'(multi), 0);
    endtask

    initial begin
        logic [13:0] sum_keep;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst crom_rd", 32'(crom_rd), 0);
        chk("rst crom_a", 32'(crom_a), 0);
        chk("rst cmd", 32'(cmd), 0);
        chk("rst cmd_valid", 32'(cmd_valid), 0);
        chk("rst checksum", 32'(checksum), 0);
        chk("rst wr_count", 32'(wr_count), 0);
        chk("rst err", 32'(err), 0);
        chk("rst finished", 32'(finished), 0);
        chk("rst host_busy", 32'(host_busy), 0);
        reset = 1'b0;

        // Script 1,5,0 with an in-order ramp image: 0+1+...+63 = 2016.
        for (int i = 0; i < 64; i++) begin
            rom[i] = 4'($urandom_range(1, 11));
            wd[i] = 8'(i);
        end
        rom[0] = 4'd1;
        rom[1] = 4'd5;
        rom[2] = 4'd0;
        run("ramp");
        chk("ramp sum2016", 32'(checksum), 2016);

        // A write strobe while finished must flag an error and leave the sum alone.
        sum_keep = checksum;
        run_id++;
        stray_en = 1;
        repeat (3) @(negedge clk);
        stray_en = 0;
        chk("stray err", 32'(err), 1);
        chk("stray checksum", 32'(checksum), 32'(sum_keep));

        swap_at = 10;
        run("swap");
        swap_at = -1;

        rom[0] = 4'd3;
        rom[1] = 4'd0;
        for (int i = 0; i < 64; i++) wd[i] = 8'($urandom);
        ignore_n = 1;
        run("noack");
        ignore_n = 0;

        for (int i = 0; i < 64; i++) rom[i] = 4'($urandom_range(1, 11));
        same_done = 1;
        run("forced");
        same_done = 0;

        for (int k = 0; k < 4; k++) begin
            int z;
            for (int i = 0; i < 64; i++) begin
                rom[i] = 4'($urandom_range(1, 11));
                wd[i] = 8'($urandom);
            end
            z = int'($urandom_range(0, 79));
            if (z < 64) rom[z] = 4'd0;
            n_writes = ($urandom_range(0, 3) == 0) ? 63 : 64;
            swap_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 62)) : -1;
            ignore_n = int'($urandom_range(0, 1));
            same_done = 1'($urandom_range(0, 1));
            run($sformatf("rnd%0d", k));
        end
        n_writes = 64;
        swap_at = -1;
        ignore_n = 0;
        same_done = 0;

        // Reset while waiting for the third command's acknowledge, then replay from address 0.
        rom[0] = 4'd2;
        rom[1] = 4'd4;
        rom[2] = 4'd6;
        rom[3] = 4'd7;
        rom[4] = 4'd0;
        ignore_n = 1;
        run_id++;
        pulse_start();
        for (int i = 0; i < 500 && pulses < 4; i++) begin
            @(negedge clk);
            #1;
        end
        chk("mid pulses", 32'(pulses), 4);
        @(posedge clk);
        #2;
        chk("mid crom_a", 32'(crom_a), 2);
        chk("mid cmd", 32'(cmd), 6);
        chk("mid err", 32'(err), 1);
        reset = 1'b1;
        #1;
        chk("mid rst crom_a", 32'(crom_a), 0);
        chk("mid rst cmd", 32'(cmd), 0);
        chk("mid rst cmd_valid", 32'(cmd_valid), 0);
        chk("mid rst err", 32'(err), 0);
        chk("mid rst host_busy", 32'(host_busy), 0);
        chk("mid rst crom_rd", 32'(crom_rd), 0);
        chk("mid rst finished", 32'(finished), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ignore_n = 0;
        for (int i = 0; i < 64; i++) wd[i] = 8'($urandom);
        run("replay");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
